// File: rtl/soc_arb_wb.sv
// ---------------------------------------------------------------------------
// soc_arb_wb -- round-robin arbiter and hold controller for the shared
// single-layer Wishbone bus between the master mux and the address decoder.
//
// One master owns the bus for a whole Wishbone cycle. The master keeps the
// bus until it drops its m_cyc_i bit, and nothing preempts it. On release,
// the search for the next owner starts just past the releasing master. An
// external bus_hold parks the bus with no owner. A new cycle is never cut
// short to honour bus_hold.
//
// Optional feature macro: SOC_ARB_WATCHDOG_EN
//   defined   : stalled-strobe watchdog, pulses wdt_err_o after TIMEOUT+1
//               consecutive stalled cycles
//   undefined : no counter is built, wdt_err_o is tied low
//
// Parameters
//   MASTERS        number of requesting masters (1..16)
//   TIMEOUT        stalled-strobe cycles tolerated before abort (>= 2)
//   IW             width of grant_idx_o (local)
// Ports
//   clk_i          bus clock
//   rst_ni         synchronous active-low reset
//   m_cyc_i        per-master cycle requests
//   bus_stb_i      strobe of the currently muxed master
//   bus_ack_i      slave acknowledge
//   bus_err_i      slave error
//   bus_rty_i      slave retry
//   bus_hold       request to park the bus
//   bus_hold_ack   bus parked, no master granted
//   grant_o        one-hot grant (registered)
//   grant_idx_o    binary index of the granted master (registered)
//   grant_valid_o  a grant is active (registered)
//   wdt_err_o      watchdog abort pulse
// ---------------------------------------------------------------------------
module soc_arb_wb #(
    parameter int  MASTERS = 2,
    parameter int  TIMEOUT = 255,
    localparam int IW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [MASTERS-1:0] m_cyc_i,
    input  logic               bus_stb_i,
    input  logic               bus_ack_i,
    input  logic               bus_err_i,
    input  logic               bus_rty_i,
    input  logic               bus_hold,
    output logic               bus_hold_ack,
    output logic [MASTERS-1:0] grant_o,
    output logic [IW-1:0]      grant_idx_o,
    output logic               grant_valid_o,
    output logic               wdt_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]      grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;

    logic               released;     // owner dropped m_cyc_i this cycle
    logic               keep;         // owner still holds the bus
    logic               issue;        // a fresh grant is given at this edge
    logic [IW-1:0]      release_ptr;  // index just past the current owner
    logic [IW-1:0]      scan_ptr;     // where the winner search starts
    logic [IW-1:0]      cand;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic               wdt;

    assign keep     = (state_q == GRANT) &&  m_cyc_i[grant_idx_q];
    assign released = (state_q == GRANT) && !m_cyc_i[grant_idx_q];

    assign release_ptr = (grant_idx_q == IW'(MASTERS - 1)) ? '0 : grant_idx_q + IW'(1);

    // A back-to-back handoff must already see the advanced pointer, so the
    // search starts past the releasing owner rather than at ptr_q.
    assign scan_ptr = (state_q == GRANT) ? release_ptr : ptr_q;

    // Round-robin winner: first requesting master at scan_ptr, scan_ptr+1, ...
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < MASTERS; i++) begin
            cand = IW'((int'(scan_ptr) + i) % MASTERS);
            if (!win_found && m_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the edge regardless of order.
        if (!rst_ni) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Hold wins over pending requests.
                if (bus_hold) begin
                    state_d = HOLD;
                end else if (win_found) begin
                    state_d = GRANT;
                    issue   = 1'b1;
                end
            end
            GRANT: begin
                if (released) begin
                    ptr_d = release_ptr;
                    if (bus_hold) begin
                        state_d = HOLD;
                    end else if (win_found) begin
                        state_d = GRANT;
                        issue   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!bus_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The one-hot vector, index and valid flag are computed together so
        // the three registered outputs can never disagree.
        grant_valid_d = issue || keep;
        grant_idx_d   = issue ? win_idx : (keep ? grant_idx_q : '0);
        grant_d       = '0;
        if (grant_valid_d) grant_d[grant_idx_d] = 1'b1;
    end

    // ---------------- output logic ----------------
    always_comb begin
        grant_o       = grant_q;
        grant_idx_o   = grant_idx_q;
        grant_valid_o = grant_valid_q;
        bus_hold_ack  = (state_q == HOLD);
        wdt_err_o     = wdt;
    end

`ifdef SOC_ARB_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          term;

    assign term = bus_ack_i || bus_err_i || bus_rty_i;

    // A real termination in the same cycle wins over the abort.
    assign wdt = (state_q == GRANT) && bus_stb_i && (cnt_q == TW'(TIMEOUT)) && !term;

    // Counts consecutive stalled strobe cycles of the current owner. Any
    // termination, idle strobe, abort pulse or change of owner restarts it,
    // so the pulse re-arms if the master keeps strobing.
    always_comb begin
        cnt_d = '0;
        if (keep && bus_stb_i && !term && !wdt) begin
            cnt_d = (cnt_q == TW'(TIMEOUT)) ? cnt_q : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    // Slave-side termination and strobe only feed the watchdog.
    logic wdt_unused;
    assign wdt_unused = ^{bus_stb_i, bus_ack_i, bus_err_i, bus_rty_i, (TIMEOUT >= 2)};
    assign wdt        = 1'b0;
`endif

endmodule
